// File: rtl/bip_control_unit.sv
// bip_control_unit: instruction sequencer for the BIP accumulator datapath.
// Fetches from synchronous program memory, decodes the latched instruction and
// drives datapath / data-memory controls through a small run/halt FSM.
// Optional: define BIP_CYCLE_COUNT_EN to add a saturating 32-bit o_cycle_count.
module bip_control_unit #(
    parameter int PC_WIDTH      = 11,
    parameter int OPERAND_WIDTH = 11,
    parameter int INSTR_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [INSTR_WIDTH-1:0]   i_instruction,
    output logic [PC_WIDTH-1:0]      o_pc,
    output logic                     o_prog_rd,
    output logic [OPERAND_WIDTH-1:0] o_operand,
    output logic [1:0]               o_sel_a,
    output logic                     o_sel_b,
    output logic                     o_write_acc,
    output logic                     o_operation,
    output logic                     o_mem_rd,
    output logic                     o_mem_wr,
`ifdef BIP_CYCLE_COUNT_EN
    output logic [31:0]              o_cycle_count,
`endif
    output logic                     o_halted
);

    localparam int OPC_W = INSTR_WIDTH - OPERAND_WIDTH;

    localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [INSTR_WIDTH-1:0]   r_ir;
    logic [OPC_W-1:0]         w_opcode;

    logic       w_ld_ir;
    logic       w_pc_inc;
    logic       w_prog_rd;
    logic       w_write_acc;
    logic       w_mem_rd;
    logic       w_mem_wr;
    logic [1:0] w_sel_a;
    logic       w_sel_b;
    logic       w_operation;

    assign w_opcode = r_ir[INSTR_WIDTH-1:OPERAND_WIDTH];

    // State, program counter and instruction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (w_ld_ir)
                r_ir <= i_instruction;
            if (w_pc_inc)
                r_pc <= r_pc + PC_WIDTH'(1);
        end
    end

    // Next-state and control decode from state and IR.
    always_comb begin
        w_next      = r_state;
        w_ld_ir     = 1'b0;
        w_pc_inc    = 1'b0;
        w_prog_rd   = 1'b0;
        w_write_acc = 1'b0;
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_sel_a     = 2'd0;
        w_sel_b     = 1'b0;
        w_operation = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                w_prog_rd = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                w_ld_ir = 1'b1;
                w_next  = S_EXEC;
            end
            S_EXEC: begin
                w_pc_inc = 1'b1;
                w_next   = S_FETCH;
                case (w_opcode)
                    OP_HLT: begin
                        w_pc_inc = 1'b0;
                        w_next   = S_HALT;
                    end
                    OP_STO: w_mem_wr = 1'b1;
                    OP_LD, OP_ADD, OP_SUB: begin
                        // Operand fetch from data memory; pc advances after MEM.
                        w_mem_rd = 1'b1;
                        w_pc_inc = 1'b0;
                        w_next   = S_MEM;
                    end
                    OP_LDI: begin
                        w_write_acc = 1'b1;
                        w_sel_a     = 2'd1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        w_write_acc = 1'b1;
                        w_sel_a     = 2'd2;
                        w_sel_b     = 1'b1;
                        w_operation = (w_opcode == OP_SUBI);
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                w_write_acc = 1'b1;
                w_pc_inc    = 1'b1;
                w_next      = S_FETCH;
                if (w_opcode == OP_ADD || w_opcode == OP_SUB) begin
                    w_sel_a     = 2'd2;
                    w_sel_b     = 1'b0;
                    w_operation = (w_opcode == OP_SUB);
                end
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;
    logic        w_active;

    assign w_active = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                      (r_state == S_EXEC)  || (r_state == S_MEM);

    // Saturating count of cycles spent running instructions.
    always_ff @(posedge clk) begin
        if (rst)
            r_cycle_count <= '0;
        else if (w_active && r_cycle_count != 32'hFFFF_FFFF)
            r_cycle_count <= r_cycle_count + 32'd1;
    end

    assign o_cycle_count = r_cycle_count;
`endif

    // Strobes are masked while rst is high so a reset landing on an EXEC or
    // MEM cycle never lets a memory or accumulator write through at that edge.
    assign o_prog_rd   = w_prog_rd   & ~rst;
    assign o_write_acc = w_write_acc & ~rst;
    assign o_mem_rd    = w_mem_rd    & ~rst;
    assign o_mem_wr    = w_mem_wr    & ~rst;
    assign o_sel_a     = w_sel_a;
    assign o_sel_b     = w_sel_b;
    assign o_operation = w_operation;
    assign o_pc        = r_pc;
    assign o_operand   = r_ir[OPERAND_WIDTH-1:0];
    assign o_halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: program/data memories and an accumulator
// around the DUT, per-instruction vector table, directed corner sequences and
// random programs checked against an instruction-level reference interpreter.
module tb_bip_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_instruction = '0;
    logic [10:0] o_pc;
    logic        o_prog_rd;
    logic [10:0] o_operand;
    logic [1:0]  o_sel_a;
    logic        o_sel_b;
    logic        o_write_acc;
    logic        o_operation;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic        o_halted;
`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] o_cycle_count;
`endif

    bip_control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_instruction (i_instruction),
        .o_pc          (o_pc),
        .o_prog_rd     (o_prog_rd),
        .o_operand     (o_operand),
        .o_sel_a       (o_sel_a),
        .o_sel_b       (o_sel_b),
        .o_write_acc   (o_write_acc),
        .o_operation   (o_operation),
        .o_mem_rd      (o_mem_rd),
        .o_mem_wr      (o_mem_wr),
`ifdef BIP_CYCLE_COUNT_EN
        .o_cycle_count (o_cycle_count),
`endif
        .o_halted      (o_halted)
    );

    always #5 clk = ~clk;

    logic [15:0] prog [0:2047];
    logic [15:0] dmem [0:2047];
    logic [15:0] mm   [0:2047];
    logic [15:0] rdata = '0;
    logic [15:0] acc   = '0;

    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] sext(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

    function automatic logic [15:0] mk(input int op, input int opnd);
        logic [4:0]  o5;
        logic [10:0] a11;
        o5  = 5'(op);
        a11 = 11'(opnd);
        return {o5, a11};
    endfunction

    // Synchronous program and data memories.
    always @(posedge clk) begin
        if (o_prog_rd) i_instruction <= prog[o_pc];
        if (o_mem_rd)  rdata <= dmem[o_operand];
        if (o_mem_wr)  dmem[o_operand] <= acc;
    end

    // Accumulator datapath, written on the negedge inside the asserting cycle.
    always @(negedge clk) begin
        if (rst) acc <= '0;
        else if (o_write_acc) begin
            case (o_sel_a)
                2'd0: acc <= rdata;
                2'd1: acc <= sext(o_operand);
                default: begin
                    if (o_operation) acc <= acc - (o_sel_b ? sext(o_operand) : rdata);
                    else             acc <= acc + (o_sel_b ? sext(o_operand) : rdata);
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl();
        return {o_write_acc, o_mem_rd, o_mem_wr, o_sel_a, o_sel_b, o_operation};
    endfunction

    // One clock, sample 1ns after the edge, check the strobe exclusivity rules.
    task automatic step();
        int n;
        @(posedge clk);
        #1;
        n = int'(o_write_acc) + int'(o_mem_rd) + int'(o_mem_wr);
        chk("strobe_excl", {31'd0, (n > 1) || (o_prog_rd && o_mem_wr)}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_start = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic clear_mems();
        for (int k = 0; k < 2048; k++) begin
            prog[k] = 16'h0000;
            dmem[k] = 16'h0000;
        end
    endtask

    task automatic run_to_halt(input int budget, output int cyc);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        cyc = 0;
        while (!o_halted && cyc < budget) begin
            step();
            cyc++;
        end
        chk("halt_reached", {31'd0, o_halted}, 32'd1);
    endtask

    // Instruction-level interpreter over prog[] and mm[].
    task automatic model_run(output int cyc, output logic [10:0] pcend);
        logic [10:0] pc;
        logic [15:0] a, ins;
        logic [10:0] opnd;
        bit done;
        pc = '0; a = '0; cyc = 0; done = 0;
        while (!done) begin
            ins  = prog[pc];
            opnd = ins[10:0];
            cyc += 3;
            case (ins[15:11])
                5'd0: done = 1;
                5'd1: mm[opnd] = a;
                5'd2: begin a = mm[opnd]; cyc++; end
                5'd3: a = sext(opnd);
                5'd4: begin a = a + mm[opnd]; cyc++; end
                5'd5: a = a + sext(opnd);
                5'd6: begin a = a - mm[opnd]; cyc++; end
                5'd7: a = a - sext(opnd);
                default: ;
            endcase
            if (!done) pc = pc + 11'd1;
        end
        pcend = pc;
    endtask

    typedef struct {
        logic [15:0] instr;
        int          lat;
        logic [6:0]  ex;   // {wacc, mrd, mwr, sel_a, sel_b, op} in EXEC
        logic [6:0]  mem;  // same, in MEM (4-cycle ops only)
    } vec_t;

    vec_t tbl [0:10];

    initial begin
        int cyc;
        int mcyc;
        logic [10:0] mpc;

        tbl[0]  = '{mk(0, 0),       3, 7'b0000000, 7'b0000000}; // HLT
        tbl[1]  = '{mk(1, 12),      3, 7'b0010000, 7'b0000000}; // STO
        tbl[2]  = '{mk(2, 4),       4, 7'b0100000, 7'b1000000}; // LD
        tbl[3]  = '{mk(3, 11'h123), 3, 7'b1000100, 7'b0000000}; // LDI
        tbl[4]  = '{mk(4, 7),       4, 7'b0100000, 7'b1001000}; // ADD
        tbl[5]  = '{mk(5, 11'h7FF), 3, 7'b1001010, 7'b0000000}; // ADDI
        tbl[6]  = '{mk(6, 9),       4, 7'b0100000, 7'b1001001}; // SUB
        tbl[7]  = '{mk(7, 1),       3, 7'b1001011, 7'b0000000}; // SUBI
        tbl[8]  = '{mk(8, 5),       3, 7'b0000000, 7'b0000000}; // NOP low
        tbl[9]  = '{16'hFFFF,       3, 7'b0000000, 7'b0000000}; // NOP 11111/7FF
        tbl[10] = '{mk(20, 11'h400),3, 7'b0000000, 7'b0000000}; // NOP mid

        clear_mems();
        do_reset();
        chk("rst_pc", {21'd0, o_pc}, 32'd0);
        chk("rst_ctl", {25'd0, ctl()}, 32'd0);
        chk("rst_prog_rd", {31'd0, o_prog_rd}, 32'd0);
        chk("rst_halted", {31'd0, o_halted}, 32'd0);
        chk("rst_operand", {21'd0, o_operand}, 32'd0);
`ifdef BIP_CYCLE_COUNT_EN
        chk("rst_cc", o_cycle_count, 32'd0);
`endif
        // IDLE ignores time without start.
        step(); step();
        chk("idle_no_fetch", {31'd0, o_prog_rd}, 32'd0);

        // Per-instruction control vectors and latency.
        for (int i = 0; i <= 10; i++) begin
            clear_mems();
            prog[0] = tbl[i].instr;
            do_reset();
            i_start = 1'b1;
            step();
            i_start = 1'b0;
            chk("v_fetch_rd", {31'd0, o_prog_rd}, 32'd1);
            chk("v_fetch_pc", {21'd0, o_pc}, 32'd0);
            step();
            chk("v_decode_ctl", {24'd0, o_prog_rd, ctl()}, 32'd0);
            step();
            chk("v_exec_ctl", {25'd0, ctl()}, {25'd0, tbl[i].ex});
            chk("v_exec_operand", {21'd0, o_operand}, {21'd0, tbl[i].instr[10:0]});
            if (tbl[i].lat == 4) begin
                step();
                chk("v_mem_ctl", {25'd0, ctl()}, {25'd0, tbl[i].mem});
                chk("v_mem_pc", {21'd0, o_pc}, 32'd0);
            end
            step();
            if (tbl[i].instr[15:11] == 5'd0) begin
                chk("v_halted", {31'd0, o_halted}, 32'd1);
                chk("v_halt_pc", {21'd0, o_pc}, 32'd0);
            end else begin
                chk("v_next_fetch", {31'd0, o_prog_rd}, 32'd1);
                chk("v_next_pc", {21'd0, o_pc}, 32'd1);
            end
        end

        // LDI 5; ADDI 3; STO 10; HLT
        clear_mems();
        prog[0] = mk(3, 5); prog[1] = mk(5, 3); prog[2] = mk(1, 10); prog[3] = mk(0, 0);
        do_reset();
        run_to_halt(100, cyc);
        chk("p1_mem10", {16'd0, dmem[10]}, 32'd8);
        chk("p1_pc", {21'd0, o_pc}, 32'd3);
        chk("p1_cycles", cyc, 32'd12);
`ifdef BIP_CYCLE_COUNT_EN
        chk("p1_cc", o_cycle_count, 32'd12);
`endif
        // HALT ignores start for 10 cycles.
        i_start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("halt_hold", {20'd0, o_halted, o_prog_rd, o_pc, 1'b0, 1'b0}, {20'd0, 1'b1, 1'b0, 11'd3, 2'b00});
            chk("halt_ctl", {25'd0, ctl()}, 32'd0);
        end
        i_start = 1'b0;
`ifdef BIP_CYCLE_COUNT_EN
        chk("halt_cc_frozen", o_cycle_count, 32'd12);
`endif

        // mem[4]=100; LD 4; SUB 4; SUBI 1; STO 5; HLT
        clear_mems();
        dmem[4] = 16'd100;
        prog[0] = mk(2, 4); prog[1] = mk(6, 4); prog[2] = mk(7, 1);
        prog[3] = mk(1, 5); prog[4] = mk(0, 0);
        do_reset();
        run_to_halt(100, cyc);
        chk("p2_mem5", {16'd0, dmem[5]}, 32'h0000FFFF);
        chk("p2_cycles", cyc, 32'd4 + 32'd4 + 32'd3 + 32'd3 + 32'd3);

        // Reset landing on the EXEC cycle of a STO.
        clear_mems();
        prog[0] = mk(3, 7); prog[1] = mk(1, 9); prog[2] = mk(0, 0);
        do_reset();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("r_sto_exec", {31'd0, o_mem_wr}, 32'd1);
        rst = 1'b1;
        #1;
        chk("r_no_wr_strobe", {31'd0, o_mem_wr}, 32'd0);
        step();
        rst = 1'b0;
        chk("r_mem9", {16'd0, dmem[9]}, 32'd0);
        chk("r_pc", {21'd0, o_pc}, 32'd0);
        step();
        chk("r_idle", {30'd0, o_prog_rd, o_halted}, 32'd0);
        run_to_halt(100, cyc);
        chk("r_rerun_mem9", {16'd0, dmem[9]}, 32'd7);
        chk("r_rerun_pc", {21'd0, o_pc}, 32'd2);

        // PC wrap 2047 -> 0.
        clear_mems();
        for (int k = 0; k < 2048; k++) prog[k] = mk(8, 0);
        do_reset();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        cyc = 0;
        while (!(o_prog_rd && o_pc == 11'd2047) && cyc < 7000) begin
            step();
            cyc++;
        end
        chk("w_reach_2047", {21'd0, o_pc}, 32'd2047);
        prog[0] = mk(3, 9); prog[1] = mk(1, 30); prog[2] = mk(0, 0);
        step(); step(); step();
        chk("w_wrap_fetch", {20'd0, o_prog_rd, o_pc}, {20'd0, 1'b1, 11'd0});
        cyc = 0;
        while (!o_halted && cyc < 100) begin
            step();
            cyc++;
        end
        chk("w_halted", {31'd0, o_halted}, 32'd1);
        chk("w_mem30", {16'd0, dmem[30]}, 32'd9);
        chk("w_pc", {21'd0, o_pc}, 32'd2);

        // Random programs against the interpreter.
        for (int r = 0; r < 10; r++) begin
            int len;
            int op;
            clear_mems();
            for (int k = 0; k < 16; k++) dmem[k] = 16'($urandom);
            len = $urandom_range(5, 25);
            for (int k = 0; k < len; k++) begin
                op = $urandom_range(1, 10);
                if (op >= 8)
                    prog[k] = mk($urandom_range(8, 31), $urandom_range(0, 2047));
                else if (op == 1 || op == 2 || op == 4 || op == 6)
                    prog[k] = mk(op, $urandom_range(0, 15));
                else
                    prog[k] = mk(op, $urandom_range(0, 2047));
            end
            prog[len] = mk(0, 0);
            for (int k = 0; k < 2048; k++) mm[k] = dmem[k];
            model_run(mcyc, mpc);
            do_reset();
            run_to_halt(200, cyc);
            chk("rnd_cycles", cyc, mcyc);
            chk("rnd_pc", {21'd0, o_pc}, {21'd0, mpc});
`ifdef BIP_CYCLE_COUNT_EN
            chk("rnd_cc", o_cycle_count, mcyc);
`endif
            for (int k = 0; k < 16; k++)
                chk("rnd_mem", {16'd0, dmem[k]}, {16'd0, mm[k]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
